// File: rtl/unidade_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; MULT_DIV_SIGNED_EN builds signed ops.
// Latency: start at edge N, result in HI/LO and done pulse at edge N+33.
// Backpressure: busy high from edge N through N+32; start/mthi/mtlo ignored while busy.
module unidade_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t state, nextState;
  logic [CW-1:0]      cnt;
  logic               isDiv, divZero, ge;
  logic [WIDTH-1:0]   opnd, upper, lower, magA, magB;
  logic [WIDTH-1:0]   nextRem, quo, rem, resHi, resLo;
  logic [WIDTH:0]     addSum, shifted;
  logic [2*WIDTH-1:0] prod;

`ifdef MULT_DIV_SIGNED_EN
  logic signA, signB, negRes, negRem;

  assign signA = ~op[0] & a[WIDTH-1];
  assign signB = ~op[0] & b[WIDTH-1];
  assign magA  = signA ? -a : a;
  assign magB  = signB ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negRes <= 1'b0;
      negRem <= 1'b0;
    end else if (state == IDLE && start) begin
      negRes <= signA ^ signB;
      negRem <= signA;
    end
  end
`else
  // Signed and unsigned opcodes are identical in this build.
  logic unusedOp;
  assign unusedOp = op[0];
  assign magA     = a;
  assign magB     = b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // upper:lower is the product accumulator for multiply, remainder:dividend/quotient for divide.
  always_comb begin
    addSum  = {1'b0, upper} + (lower[0] ? {1'b0, opnd} : '0);
    shifted = {upper, lower[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    nextRem = shifted[WIDTH-1:0] - opnd;
    prod    = {upper, lower};
    quo     = lower;
    rem     = upper;
`ifdef MULT_DIV_SIGNED_EN
    if (negRes) begin
      prod = -prod;
      quo  = -quo;
    end
    if (negRem) rem = -rem;
`endif
    resHi = isDiv ? rem : prod[2*WIDTH-1:WIDTH];
    resLo = isDiv ? (divZero ? '1 : quo) : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      isDiv   <= 1'b0;
      divZero <= 1'b0;
      opnd    <= '0;
      upper   <= '0;
      lower   <= '0;
    end else begin
      busy <= (nextState != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            isDiv   <= op[1];
            divZero <= op[1] && (b == '0);
            opnd    <= op[1] ? magB : magA;
            lower   <= op[1] ? magA : magB;
            upper   <= '0;
            cnt     <= '0;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (isDiv) begin
            upper <= ge ? nextRem : shifted[WIDTH-1:0];
            lower <= {lower[WIDTH-2:0], ge};
          end else begin
            upper <= addSum[WIDTH:1];
            lower <= {addSum[0], lower[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi   <= resHi;
          lo   <= resLo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_mult_div.sv
// Randomized bench for unidade_mult_div against a cycle-count/arithmetic reference model.
module tb_unidade_mult_div;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int   vectors = 0;
  int   errors  = 0;
  logic chkEn   = 1'b0;
  int   lat;

  logic        mBusy, mDone;
  logic [31:0] mHi, mLo;
  logic [63:0] pend;
  int          mCnt;

  always #5 clk = ~clk;

  unidade_mult_div #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic          sgn;
    longint        sx, sy, sq, sr;
    longint unsigned ux, uy;
`ifdef MULT_DIV_SIGNED_EN
    sgn = !o[0];
`else
    sgn = 1'b0;
`endif
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (!o[1]) return sgn ? 64'(sx * sy) : 64'(ux * uy);
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (sgn) begin
      sq = sx / sy;
      sr = sx % sy;
      return {sr[31:0], sq[31:0]};
    end
    return {32'(ux % uy), 32'(ux / uy)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy <= 1'b0; mDone <= 1'b0; mHi <= '0; mLo <= '0; mCnt <= 0; pend <= '0;
    end else begin
      mDone <= 1'b0;
      if (!mBusy) begin
        if (start) begin
          pend  <= refResult(op, a, b);
          mBusy <= 1'b1;
          mCnt  <= 33;
        end else begin
          if (mthi) mHi <= wdata;
          if (mtlo) mLo <= wdata;
        end
      end else if (mCnt == 1) begin
        mBusy      <= 1'b0;
        mDone      <= 1'b1;
        {mHi, mLo} <= pend;
      end else begin
        mCnt <= mCnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      check("busy", 32'(busy), 32'(mBusy));
      check("done", 32'(done), 32'(mDone));
      check("hi",   hi, mHi);
      check("lo",   lo, mLo);
    end
  end

  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic doOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    waitDone(n);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chkEn = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    doOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_lat", lat, 32'd33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    doOp(2'b00, 32'hFFFF_FFFD, 32'd7, lat);
`ifdef MULT_DIV_SIGNED_EN
    check("mult_hi", hi, 32'hFFFF_FFFF);
`else
    check("mult_hi", hi, 32'h0000_0006);
`endif
    check("mult_lo", lo, 32'hFFFF_FFEB);

    doOp(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
`ifdef MULT_DIV_SIGNED_EN
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
`else
    check("div_lo", lo, 32'h7FFF_FFFC);
    check("div_hi", hi, 32'h0000_0001);
`endif

    doOp(2'b11, 32'd100, 32'd0, lat);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'h0000_0064);

    start = 1'b1; op = 2'b01; a = 32'h10; b = 32'h20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd5; b = 32'd0; mthi = 1'b1; wdata = 32'h1234;
    repeat (3) @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    waitDone(lat);
    check("busyign_hi", hi, 32'h0000_0000);
    check("busyign_lo", lo, 32'h0000_0200);
    mtlo = 1'b1; wdata = 32'h0000_ABCD;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h0000_ABCD);
    check("mtlo_hi", hi, 32'h0000_0000);

    start = 1'b1; op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    doOp(2'b01, 32'd6, 32'd7, lat);
    check("rst_multu_lat", lat, 32'd33);
    check("rst_multu_lo", lo, 32'd42);
    check("rst_multu_hi", hi, 32'd0);

    doOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
`ifdef MULT_DIV_SIGNED_EN
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);
`else
    check("ovf_lo", lo, 32'h0000_0000);
    check("ovf_hi", hi, 32'h8000_0000);
`endif

    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 7) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
      mthi  = ($urandom_range(0, 5) == 0);
      mtlo  = ($urandom_range(0, 5) == 0);
      wdata = $urandom;
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (40) @(negedge clk);

    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/unidade_mult_div.md
# unidade_mult_div

Iterative multiply/divide unit for the single-cycle MIPS datapath, sitting directly downstream of the register file. It takes the two operands read on ReadData1/ReadData2 for MULT, MULTU, DIV and DIVU, computes a 64-bit result over 33 cycles, and holds it in architectural HI/LO registers. MFHI/MFLO read those registers; MTHI/MTLO write them. The control unit stalls the PC while `busy` is high.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each WIDTH bits wide.
- `clk` input 1: single clock. All state updates on the posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request an operation. Sampled only when `busy`=0.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` input WIDTH: rs operand (ReadData1). Multiplicand or dividend.
- `b` input WIDTH: rt operand (ReadData2). Multiplier or divisor.
- `mthi` input 1: write `wdata` into HI.
- `mtlo` input 1: write `wdata` into LO.
- `wdata` input WIDTH: MTHI/MTLO data.
- `busy` output 1: high while an operation is in flight.
- `done` output 1: one-cycle pulse when the result lands in HI/LO.
- `hi` output WIDTH: HI register, which holds the product upper half or the remainder.
- `lo` output WIDTH: LO register, which holds the product lower half or the quotient.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with `start`=1: latch the operand magnitudes and the signs. Go to RUN. Iteration counter = 0.
- RUN: one bit per cycle. Multiply uses shift-add. Divide uses restoring shift-subtract. After 32 iterations, go to FIX.
- FIX: apply the sign corrections and write HI/LO. Pulse `done`. Return to IDLE.
- Signed rules:
  - Product is negated if sign(a) XOR sign(b).
  - Quotient is negated if sign(a) XOR sign(b).
  - Remainder takes the sign of `a`.
- Arithmetic uses 33-bit partial remainders and a 64-bit product accumulator. No saturation.
- Divide by zero, all ops: LO = all ones, HI = `a` unmodified. Latency is unchanged. No trap.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- `start` while `busy`=1: ignored. The operation in flight is undisturbed.
- `mthi`/`mtlo`: honoured only in IDLE with `start`=0. Otherwise ignored. Both may be asserted in the same cycle.
- `start` and `mthi`/`mtlo` together in IDLE: `start` wins and the moves are dropped.
- HI/LO change only on a completed operation, a move, or reset.

## Timing
- Reset (`rst_n`=0, asynchronous): state = IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0. Partial result discarded.
- `start` accepted at edge N:
  - `busy`=1 from edge N.
  - RUN iterations occur at edges N+1 through N+32.
  - FIX at edge N+33: HI/LO are updated, `done`=1, `busy`=0.
  - `done` deasserts at edge N+34.
- Back-to-back: a `start` sampled at edge N+34 (the `done` cycle) is accepted. Issue interval is 34 cycles.
- `busy` is registered. There is no combinational path from `start` to `busy`.
- MTHI/MTLO take effect at the sampling edge and are visible the next cycle.
- `hi`/`lo` are registered outputs. They are stable for the whole `done` cycle.
- `rst_n` release is synchronous to `clk` upstream. The block does not resynchronize it.

## Configuration
- `MULT_DIV_SIGNED_EN` defined: MULT and DIV perform the signed pre-negation and post-negation described above.
- `MULT_DIV_SIGNED_EN` undefined:
  - MULT executes as MULTU and DIV executes as DIVU.
  - The sign-correction logic is not built.
  - The signed divide-by-zero and overflow rules collapse to the unsigned ones.
  - Latency is unchanged.

## Test plan
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> `done` at edge N+33; HI=0xFFFFFFFE, LO=0x00000001; `busy` high at edges N through N+32.
- MULT, a=-3, b=7:
  - With the macro -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Without the macro -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV, a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU, a=100, b=0 -> LO=0xFFFFFFFF, HI=0x00000064.
- Extra `start` pulses during `busy`, plus MTHI wdata=0x1234 during `busy` -> ignored; the original result lands unchanged.
  - Then MTLO wdata=0xABCD in IDLE -> LO=0xABCD next cycle.
- Drop `rst_n` at edge N+15 of a DIV -> immediately `busy`=0, `done`=0, HI=LO=0.
  - A new MULTU 6×7 after release -> LO=42, HI=0 at its edge N'+33.
